// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared register-file defaults and the context-level width
//                helper, also used by the CSR/interrupt controller.
//  Revision    : 1.0
// ============================================================================
package rf_pkg;

    localparam int RF_XLEN      = 32;
    localparam int RF_NREG      = 32;
    localparam int RF_CTX_DEPTH = 4;

    // Bits needed to hold a nesting level in 0..depth (never narrower than 1).
    function automatic int lvl_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_ctx_stack_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_ctx_stack_if
//  Description : Access/control bundle between the pipeline and rf_ctx_stack.
//  Revision    : 1.0
// ============================================================================
interface rf_ctx_stack_if
    import rf_pkg::*;
#(
    parameter int XLEN      = RF_XLEN,
    parameter int NREG      = RF_NREG,
    parameter int NRP       = 2,
    parameter int CTX_DEPTH = RF_CTX_DEPTH
) ();
    localparam int AW = $clog2(NREG);
    localparam int LW = lvl_width(CTX_DEPTH);

    logic                 we;
    logic [AW-1:0]        wa;
    logic [XLEN-1:0]      wd;
    logic [NRP*AW-1:0]    ra;
    logic [NRP*XLEN-1:0]  rd;
    logic                 save;
    logic                 restore;
    logic [LW-1:0]        level;
    logic                 full;
    logic                 empty;
    logic                 ovf;
    logic                 unf;
    logic                 err;

    modport master (
        output we, wa, wd, ra, save, restore,
        input  rd, level, full, empty, ovf, unf, err
    );

    modport slave (
        input  we, wa, wd, ra, save, restore,
        output rd, level, full, empty, ovf, unf, err
    );

endinterface
`default_nettype wire

// File: rtl/rf_bank.sv
`default_nettype none
// ============================================================================
//  Module      : rf_bank
//  Description : One register context: data storage, per-register valid bits
//                with single-edge clear, one write port, NRP raw read ports.
//  Revision    : 1.0
// ============================================================================
module rf_bank #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRP  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                clr,
    input  wire logic                we,
    input  wire logic [AW-1:0]       wa,
    input  wire logic [XLEN-1:0]     wd,
    input  wire logic [NRP*AW-1:0]   ra,
    output      logic [NRP*XLEN-1:0] rd
);
    logic [XLEN-1:0] mem_q [NREG];
    logic [NREG-1:0] valid_q;
    logic [NREG-1:0] valid_d;

    always_comb begin
        valid_d = valid_q;
        if (clr) begin
            valid_d = '0;
        end else if (we) begin
            valid_d[wa] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data array carries no reset; the valid bits alone define reset contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wa] <= wd;
        end
    end

    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = ra[p*AW +: AW];
        assign rd[p*XLEN +: XLEN] = valid_q[addr] ? mem_q[addr] : '0;
    end

endmodule
`default_nettype wire

// File: rtl/rf_ctx_stack.sv
`default_nettype none
// ============================================================================
//  Module      : rf_ctx_stack
//  Description : Register file with a hardware context stack; save/restore
//                move a bank pointer, never copy registers.
//  Revision    : 1.0
// ============================================================================
module rf_ctx_stack
    import rf_pkg::*;
#(
    parameter int XLEN      = RF_XLEN,
    parameter int NREG      = RF_NREG,
    parameter int NRP       = 2,
    parameter int CTX_DEPTH = RF_CTX_DEPTH
) (
    input  wire logic      clk,
    input  wire logic      rst,
    rf_ctx_stack_if.slave  bus
);
    localparam int AW = $clog2(NREG);
    localparam int LW = lvl_width(CTX_DEPTH);
    localparam int NB = CTX_DEPTH + 1;
    localparam logic [LW-1:0] C_MAX_LVL = LW'(CTX_DEPTH);

    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          err_q, err_d;

    logic full_w, empty_w, push_w, wr_w, bypass_ok_w;
    logic [LW-1:0] level_inc_w;

    assign full_w      = (level_q == C_MAX_LVL);
    assign empty_w     = (level_q == '0);
    assign level_inc_w = level_q + LW'(1);
    assign push_w      = bus.save && !bus.restore && !full_w;
    // Any save/restore request, legal or not, swallows the write.
    assign bypass_ok_w = bus.we && !bus.save && !bus.restore;
    assign wr_w        = bypass_ok_w && (bus.wa != '0);

    always_comb begin
        level_d = level_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        err_d   = err_q;
        if (bus.save && bus.restore) begin
            err_d = 1'b1;
        end else if (bus.save) begin
            if (full_w) ovf_d   = 1'b1;
            else        level_d = level_inc_w;
        end else if (bus.restore) begin
            if (empty_w) unf_d   = 1'b1;
            else         level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            err_q   <= err_d;
        end
    end

    logic [NRP*XLEN-1:0] bank_rd [NB];

    // The bank being entered is wiped on the push edge, so stale data from an
    // earlier, deeper interrupt can never be observed.
    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic bank_we, bank_clr;
        assign bank_we  = wr_w   && (level_q     == LW'(b));
        assign bank_clr = push_w && (level_inc_w == LW'(b));

        rf_bank #(
            .XLEN (XLEN),
            .NREG (NREG),
            .NRP  (NRP),
            .AW   (AW)
        ) u_bank (
            .clk (clk),
            .rst (rst),
            .clr (bank_clr),
            .we  (bank_we),
            .wa  (bus.wa),
            .wd  (bus.wd),
            .ra  (bus.ra),
            .rd  (bank_rd[b])
        );
    end

    logic [NRP*XLEN-1:0] rd_sel;

    always_comb begin
        rd_sel = '0;
        for (int b = 0; b < NB; b++) begin
            if (level_q == LW'(b)) rd_sel = bank_rd[b];
        end
    end

    logic [NRP*XLEN-1:0] rd_w;

    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [AW-1:0] ra_p;
        assign ra_p = bus.ra[p*AW +: AW];
        assign rd_w[p*XLEN +: XLEN] =
            (ra_p == '0)                      ? '0     :
            (bypass_ok_w && bus.wa == ra_p)   ? bus.wd :
                                                rd_sel[p*XLEN +: XLEN];
    end

    assign bus.rd    = rd_w;
    assign bus.level = level_q;
    assign bus.full  = full_w;
    assign bus.empty = empty_w;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
    assign bus.err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_ctx_stack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_ctx_stack
//  Description : Directed and randomized checks of rf_ctx_stack against a
//                context-stack reference model.
//  Revision    : 1.0
// ============================================================================
module tb_rf_ctx_stack;
    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int NRP   = 2;
    localparam int DEPTH = 4;

    typedef logic [NREG-1:0][XLEN-1:0] ctx_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_ctx_stack_if #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .CTX_DEPTH(DEPTH)) bus ();

    rf_ctx_stack #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .CTX_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: live context plus a stack of saved contexts.
    ctx_t cur;
    ctx_t stk[$];
    int   m_lvl;
    bit   m_ovf, m_unf, m_err;

    function automatic logic [XLEN-1:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return '0;
        if (bus.we && bus.wa == a && !bus.save && !bus.restore) return bus.wd;
        return cur[a];
    endfunction

    task automatic model_edge();
        if (rst) begin
            cur = '0; stk.delete(); m_lvl = 0;
            m_ovf = 0; m_unf = 0; m_err = 0;
        end else if (bus.save && bus.restore) begin
            m_err = 1;
        end else if (bus.save) begin
            if (m_lvl == DEPTH) m_ovf = 1;
            else begin stk.push_back(cur); cur = '0; m_lvl++; end
        end else if (bus.restore) begin
            if (m_lvl == 0) m_unf = 1;
            else begin cur = stk.pop_back(); m_lvl--; end
        end else if (bus.we && bus.wa != 5'd0) begin
            cur[bus.wa] = bus.wd;
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic sv, input logic rs,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        @(negedge clk);
        bus.we = we; bus.wa = wa; bus.wd = wd;
        bus.save = sv; bus.restore = rs;
        bus.ra = {ra1, ra0};
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_read(input logic [4:0] ra0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, ra0, 5'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_read(5'd0); tick(); tick();
        rst = 1'b0;
        idle_read(5'd0);
        checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", bus.level); end
        checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin errors++; $display("FAIL reset_empty_full got %b%b exp 10", bus.empty, bus.full); end
        checks++; if ({bus.ovf, bus.unf, bus.err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {bus.ovf, bus.unf, bus.err}); end
        for (int a = 0; a < NREG; a++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'(a), 5'(NREG-1-a));
            checks++; if (bus.rd !== 64'd0) begin errors++; $display("FAIL reset_reg%0d got %h exp 0", a, bus.rd); end
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, 5'd5, 32'h1234_5678, 1'b0, 1'b0, 5'd5, 5'd0);
        checks++; if (bus.rd[31:0] !== 32'h1234_5678) begin errors++; $display("FAIL bypass_x5 got %h exp 12345678", bus.rd[31:0]); end
        tick();
        idle_read(5'd5);
        checks++; if (bus.rd[31:0] !== 32'h1234_5678) begin errors++; $display("FAIL stored_x5 got %h exp 12345678", bus.rd[31:0]); end
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0, 5'd0);
        checks++; if (bus.rd[31:0] !== 32'd0) begin errors++; $display("FAIL x0_bypass got %h exp 0", bus.rd[31:0]); end
        tick();
        idle_read(5'd0);
        checks++; if (bus.rd[31:0] !== 32'd0) begin errors++; $display("FAIL x0_stored got %h exp 0", bus.rd[31:0]); end
    endtask

    task automatic test_save_restore();
        drive(1'b1, 5'd5, 32'hA5A5_A5A5, 1'b0, 1'b0, 5'd0, 5'd0); tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd5, 5'd0);
        checks++; if (bus.rd[31:0] !== 32'hA5A5_A5A5) begin errors++; $display("FAIL save_cycle_read got %h exp a5a5a5a5", bus.rd[31:0]); end
        tick();
        idle_read(5'd5);
        checks++; if (bus.level !== 3'd1) begin errors++; $display("FAIL save_level got %0d exp 1", bus.level); end
        checks++; if (bus.rd[31:0] !== 32'd0) begin errors++; $display("FAIL handler_x5 got %h exp 0", bus.rd[31:0]); end
        drive(1'b1, 5'd5, 32'h1, 1'b0, 1'b0, 5'd0, 5'd0); tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd5, 5'd0);
        checks++; if (bus.rd[31:0] !== 32'h1) begin errors++; $display("FAIL restore_cycle_read got %h exp 1", bus.rd[31:0]); end
        tick();
        idle_read(5'd5);
        checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL restore_level got %0d exp 0", bus.level); end
        checks++; if (bus.rd[31:0] !== 32'hA5A5_A5A5) begin errors++; $display("FAIL restored_x5 got %h exp a5a5a5a5", bus.rd[31:0]); end
    endtask

    task automatic test_nesting();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 5'd1, 32'h10 + 32'(i), 1'b0, 1'b0, 5'd0, 5'd0); tick();
            drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 5'd0); tick();
        end
        idle_read(5'd1);
        checks++; if (bus.full !== 1'b1 || bus.level !== 3'd4) begin errors++; $display("FAIL nest_full got full=%b lvl=%0d exp full=1 lvl=4", bus.full, bus.level); end
        drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 5'd0); tick();
        idle_read(5'd1);
        checks++; if (bus.ovf !== 1'b1 || bus.level !== 3'd4) begin errors++; $display("FAIL ovf got ovf=%b lvl=%0d exp ovf=1 lvl=4", bus.ovf, bus.level); end
        for (int k = DEPTH - 1; k >= 0; k--) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd0); tick();
            idle_read(5'd1);
            checks++; if (bus.rd[31:0] !== 32'h10 + 32'(k)) begin errors++; $display("FAIL unwind_x1_lvl%0d got %h exp %h", k, bus.rd[31:0], 32'h10 + 32'(k)); end
        end
        checks++; if (bus.empty !== 1'b1 || bus.unf !== 1'b0) begin errors++; $display("FAIL unwind_empty got empty=%b unf=%b exp 1 0", bus.empty, bus.unf); end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd0); tick();
        idle_read(5'd0);
        checks++; if (bus.unf !== 1'b1 || bus.level !== 3'd0) begin errors++; $display("FAIL unf got unf=%b lvl=%0d exp 1 0", bus.unf, bus.level); end
    endtask

    task automatic test_stale();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 5'd0); tick();
        drive(1'b1, 5'd3, 32'h77, 1'b0, 1'b0, 5'd0, 5'd0); tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd0); tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 5'd0); tick();
        idle_read(5'd3);
        checks++; if (bus.rd[31:0] !== 32'd0) begin errors++; $display("FAIL stale_x3 got %h exp 0", bus.rd[31:0]); end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd0); tick();
    endtask

    task automatic test_conflict();
        drive(1'b1, 5'd7, 32'h55, 1'b0, 1'b0, 5'd0, 5'd0); tick();
        drive(1'b1, 5'd7, 32'h99, 1'b1, 1'b1, 5'd7, 5'd0);
        checks++; if (bus.rd[31:0] !== 32'h55) begin errors++; $display("FAIL conflict_bypass got %h exp 55", bus.rd[31:0]); end
        tick();
        idle_read(5'd7);
        checks++; if (bus.err !== 1'b1 || bus.level !== 3'd0) begin errors++; $display("FAIL conflict_err got err=%b lvl=%0d exp 1 0", bus.err, bus.level); end
        checks++; if (bus.rd[31:0] !== 32'h55) begin errors++; $display("FAIL conflict_x7 got %h exp 55", bus.rd[31:0]); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; idle_read(5'd0); tick(); rst = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 5'd0); tick();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd0); tick();
        drive(1'b1, 5'd2, 32'h5, 1'b0, 1'b0, 5'd0, 5'd0); tick();
        idle_read(5'd2);
        checks++; if (bus.level !== 3'd3 || bus.ovf !== 1'b1) begin errors++; $display("FAIL pre_rst got lvl=%0d ovf=%b exp 3 1", bus.level, bus.ovf); end
        rst = 1'b1; idle_read(5'd0); tick(); rst = 1'b0;
        idle_read(5'd2);
        checks++; if (bus.level !== 3'd0 || bus.empty !== 1'b1) begin errors++; $display("FAIL mid_rst_level got lvl=%0d empty=%b exp 0 1", bus.level, bus.empty); end
        checks++; if ({bus.ovf, bus.unf, bus.err} !== 3'b000) begin errors++; $display("FAIL mid_rst_flags got %b exp 000", {bus.ovf, bus.unf, bus.err}); end
        for (int a = 1; a < NREG; a += 2) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'(a), 5'(a - 1));
            checks++; if (bus.rd !== 64'd0) begin errors++; $display("FAIL mid_rst_reg%0d got %h exp 0", a, bus.rd); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            int r;
            logic sv, rs;
            r  = int'($urandom_range(0, 99));
            sv = (r < 14) || (r >= 96);
            rs = (r >= 14 && r < 28) || (r >= 96 && r < 98);
            rst = ($urandom_range(0, 199) == 0);
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(), sv, rs,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            checks++; if (bus.rd[31:0] !== exp_rd(bus.ra[4:0])) begin errors++; $display("FAIL rnd_rd0 n=%0d got %h exp %h", n, bus.rd[31:0], exp_rd(bus.ra[4:0])); end
            checks++; if (bus.rd[63:32] !== exp_rd(bus.ra[9:5])) begin errors++; $display("FAIL rnd_rd1 n=%0d got %h exp %h", n, bus.rd[63:32], exp_rd(bus.ra[9:5])); end
            checks++;
            if ({bus.level, bus.full, bus.empty, bus.ovf, bus.unf, bus.err} !==
                {3'(m_lvl), m_lvl == DEPTH, m_lvl == 0, m_ovf, m_unf, m_err}) begin
                errors++;
                $display("FAIL rnd_status n=%0d got %b exp %b", n,
                         {bus.level, bus.full, bus.empty, bus.ovf, bus.unf, bus.err},
                         {3'(m_lvl), m_lvl == DEPTH, m_lvl == 0, m_ovf, m_unf, m_err});
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        bus.we = 1'b0; bus.wa = '0; bus.wd = '0;
        bus.save = 1'b0; bus.restore = 1'b0; bus.ra = '0;
        cur = '0; m_lvl = 0; m_ovf = 0; m_unf = 0; m_err = 0;
        test_reset();
        test_bypass();
        test_save_restore();
        test_nesting();
        test_stale();
        test_conflict();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_ctx_stack.md
Name: rf_ctx_stack

Overview:
- Parametrised register file with a hardware context stack for nested interrupts.
- A save pushes the architectural register context and presents a zeroed register set to the handler. A restore pops back to the interrupted context.
- Context switches are single-cycle bank-pointer moves, not register copies.
- Sits in the ID/WB stage of the interrupt-capable CPU; replaces the single-shadow register file.

Parameters:
- XLEN, 32, register data width
- NREG, 32, architectural registers per context; register 0 reads 0 and ignores writes
- AW, $clog2(NREG), register address width (derived)
- NRP, 2, number of read ports
- CTX_DEPTH, 4, maximum saved contexts (nesting depth); physical banks = CTX_DEPTH+1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- we  in  1  write enable
- wa  in  AW  write address
- wd  in  XLEN  write data
- ra  in  NRP*AW  read addresses, port p at [p*AW +: AW]
- rd  out  NRP*XLEN  read data, port p at [p*XLEN +: XLEN]
- save  in  1  push context (interrupt entry)
- restore  in  1  pop context (interrupt return)
- level  out  $clog2(CTX_DEPTH+1)  current nesting level (active bank index)
- full  out  1  level == CTX_DEPTH
- empty  out  1  level == 0
- ovf  out  1  sticky: save attempted while full
- unf  out  1  sticky: restore attempted while empty
- err  out  1  sticky: save and restore asserted in same cycle

Behaviour:
- Clock and reset: one clock, clk, rising edge. Reset is synchronous and active-high on rst.
- Storage: bank[b][r] for b in 0..CTX_DEPTH, plus a valid bit per bank/register. A register whose valid bit is 0 reads as 0.
- Reset: level=0; all valid bits cleared (every register reads 0); ovf=unf=err=0; full=0, empty=1 (combinational from level).
- Priority per cycle, highest first: rst, then save&&restore, then save, then restore, then write.
- save && restore: err<=1; no level change; write discarded.
- save:
  - Not full: level<=level+1; all valid bits of bank level+1 cleared in the same edge; write discarded.
  - Full: ovf<=1; no state change; write discarded.
- restore:
  - Not empty: level<=level-1; bank level contents left stale (invalidated on the next save); write discarded.
  - Empty: unf<=1; no state change; write discarded.
- Write (no save/restore): if we && wa!=0, bank[level][wa]<=wd and its valid bit <=1.
- Reads (combinational):
  - ra_p==0 -> 0.
  - Else if we && wa==ra_p && !save && !restore -> wd (write-through bypass).
  - Else valid ? bank[level][ra_p] : 0.
  - Reads always use the pre-edge level; the switch is visible from the next cycle.
- Latency: write visible same cycle via bypass, from storage the next cycle. Context switch takes effect 1 cycle after save/restore.
- Stale banks: data in banks above level is unreachable; it is always invalidated before it can be reached.
- Sticky flags: cleared only by rst.
- Reset mid-nesting: rst at any level returns to level 0 with all registers reading 0.
- Storage holds no reset value except the valid bits; no loops over data arrays under reset.

Decomposition:
- Shared package rf_pkg: XLEN default, NREG default, CTX_DEPTH default, a function computing the level width. Package is shared with the CSR/interrupt controller.
- One sub-module: rf_bank. Single context: storage, valid vector, synchronous clear, write port, NRP raw read ports. Instantiated CTX_DEPTH+1 times. The top holds the level counter, flags, write/read muxing and bypass.

Test Plan:
- Reset, then write x5=0x1234_5678 and read ra0=5 in the same cycle -> rd0=0x1234_5678 (bypass). Next cycle, still 0x1234_5678 from storage. Write x0=0xFFFF_FFFF -> reads 0.
- x5=0xA5A5_A5A5, save -> level=1, x5 reads 0. Write x5=0x1, restore -> level=0, x5=0xA5A5_A5A5.
- Nest 4 saves with x1=level+0x10 at each level -> full=1. 5th save -> ovf=1, level stays 4. Unwind 4 restores, reading x1=0x13,0x12,0x11,0x10 in turn -> empty=1. Extra restore -> unf=1.
- Save, write x3=0x77, restore, save again -> x3 reads 0 (stale bank invalidated).
- save && restore with we=1, wa=7, wd=0x99 -> err=1, level unchanged, x7 unchanged; same-cycle read of 7 returns the old value, not 0x99.
- At level 3 with ovf=1, pulse rst -> level=0, empty=1, ovf=unf=err=0, all registers read 0.
